cory_pair_seq: RTL and testbench



---
 rtl/cory_pair_seq_pkg.sv | 19 +
 rtl/cory_pair_oreg.sv | 42 ++++
 rtl/cory_pair_seq.sv | 152 +++++++++++++++
 tb/tb_cory_pair_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cory_pair_seq_pkg.sv
// Shared definitions for the pair sequencer family: slot-state encoding
// and the padding constant used for the empty high half of a flushed word.
package cory_pair_seq_pkg;

    // Which half of the pair is being filled next
    typedef enum logic {
        S_LO = 1'b0,   // low slot empty
        S_HI = 1'b1    // low word held, waiting for the high word
    } pair_state_e;

    // Bit value replicated into the high half of a lone flushed word
    localparam logic PAD_BIT = 1'b0;

    // Even parity of a pair, handy for downstream integrity checks
    function automatic logic pair_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/cory_pair_oreg.sv
// Single-entry output register with pass-through ready. A load sets valid
// and captures data/pad; a drain without a load clears valid; a drain and a
// load in the same cycle keep valid high with the new contents.
module cory_pair_oreg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_d,
    input  logic         load_pad,
    input  logic         z_r,
    output logic         z_v,
    output logic [W-1:0] z_d,
    output logic         z_pad,
    output logic         in_r
);

    logic drn_s;

    // Upstream may write whenever the entry is empty or leaving this cycle
    assign in_r  = !z_v | z_r;
    assign drn_s = z_v & z_r;

    // Output entry: load wins over drain so back-to-back pairs have no bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z_v   <= 1'b0;
            z_d   <= {W{1'b0}};
            z_pad <= 1'b0;
        end else if (load) begin
            z_v   <= 1'b1;
            z_d   <= load_d;
            z_pad <= load_pad;
        end else if (drn_s) begin
            z_v   <= 1'b0;
        end else begin
            z_v   <= z_v;
        end
    end

endmodule

// File: rtl/cory_pair_seq.sv
// Pair sequencer: packs consecutive words of one valid/ready stream into
// registered 2N-bit pairs (first word low). A word tagged last that arrives
// with the low slot empty is emitted alone with a zero high half.
// Optional build macro CORY_PAIR_SEQ_STAT_EN adds saturating counters of
// loads (o_stat_pair) and padded loads (o_stat_pad).
module cory_pair_seq
    import cory_pair_seq_pkg::*;
#(
    parameter int N = 16,
    parameter int Z = 2*N
`ifdef CORY_PAIR_SEQ_STAT_EN
    ,
    parameter int STAT_W = 16
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_a_v,
    input  logic [N-1:0]  i_a_d,
    input  logic          i_a_last,
    output logic          o_a_r,
    output logic          o_z_v,
    output logic [Z-1:0]  o_z_d,
    output logic          o_z_pad,
    input  logic          i_z_r
`ifdef CORY_PAIR_SEQ_STAT_EN
    ,
    output logic [STAT_W-1:0] o_stat_pair,
    output logic [STAT_W-1:0] o_stat_pad
`endif
);

    pair_state_e  state_r;
    logic [N-1:0] hold_r;
    logic         acc_s;
    logic         load_s;
    logic [Z-1:0] load_d_s;
    logic         load_pad_s;

    assign acc_s = i_a_v & o_a_r;

    // Decide whether the accepted word completes a pair or a lone flush
    always_comb begin
        load_s     = 1'b0;
        load_d_s   = {Z{1'b0}};
        load_pad_s = 1'b0;
        if (acc_s) begin
            case (state_r)
                S_LO: begin
                    if (i_a_last) begin
                        load_s     = 1'b1;
                        load_d_s   = {{N{PAD_BIT}}, i_a_d};
                        load_pad_s = 1'b1;
                    end else begin
                        load_s     = 1'b0;
                    end
                end
                S_HI: begin
                    load_s     = 1'b1;
                    load_d_s   = {i_a_d, hold_r};
                    load_pad_s = 1'b0;
                end
                default: begin
                    load_s     = 1'b0;
                end
            endcase
        end else begin
            load_s = 1'b0;
        end
    end

    // Slot state and held low word; the hold is left as-is after an emit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_LO;
            hold_r  <= {N{1'b0}};
        end else if (acc_s) begin
            case (state_r)
                S_LO: begin
                    if (!i_a_last) begin
                        hold_r  <= i_a_d;
                        state_r <= S_HI;
                    end else begin
                        state_r <= S_LO;
                    end
                end
                S_HI: begin
                    state_r <= S_LO;
                end
                default: begin
                    state_r <= S_LO;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    cory_pair_oreg #(.W(Z)) u_oreg (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .load_d   (load_d_s),
        .load_pad (load_pad_s),
        .z_r      (i_z_r),
        .z_v      (o_z_v),
        .z_d      (o_z_d),
        .z_pad    (o_z_pad),
        .in_r     (o_a_r)
    );

`ifdef CORY_PAIR_SEQ_STAT_EN
    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        if (v == {STAT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(STAT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Load and padded-load counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_stat_pair <= {STAT_W{1'b0}};
            o_stat_pad  <= {STAT_W{1'b0}};
        end else if (load_s) begin
            o_stat_pair <= sat_inc(o_stat_pair);
            if (load_pad_s) begin
                o_stat_pad <= sat_inc(o_stat_pad);
            end else begin
                o_stat_pad <= o_stat_pad;
            end
        end else begin
            o_stat_pair <= o_stat_pair;
        end
    end
`endif

`ifdef SIM
`ifdef CORY_MON
    cory_monitor #(.W(Z)) u_mon (
        .clk   (clk),
        .reset (reset),
        .v     (o_z_v),
        .r     (i_z_r),
        .d     (o_z_d)
    );
`endif
`endif

endmodule

// File: tb/tb_cory_pair_seq.sv
// Self-checking bench for cory_pair_seq: directed reset/stream/flush/stall
// scenarios followed by random traffic, all scored against a word-list model.
module tb_cory_pair_seq;

    localparam int N = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_a_v = 1'b0;
    logic [N-1:0]  i_a_d = '0;
    logic          i_a_last = 1'b0;
    logic          o_a_r;
    logic          o_z_v;
    logic [2*N-1:0] o_z_d;
    logic          o_z_pad;
    logic          i_z_r = 1'b1;
`ifdef CORY_PAIR_SEQ_STAT_EN
    logic [3:0]    o_stat_pair;
    logic [3:0]    o_stat_pad;
`endif

    int n_vec = 0;
    int n_err = 0;
    int n_words = 0;

    // Model: a held low word (if any), whether an output is pending, and
    // the ordered list of {pad, pair} values the DUT still owes us.
    logic           m_have_lo = 1'b0;
    logic [N-1:0]   m_lo = '0;
    logic           m_full = 1'b0;
    logic [2*N:0]   exp_q[$];

    always #5 clk = ~clk;

    cory_pair_seq #(
        .N(N)
`ifdef CORY_PAIR_SEQ_STAT_EN
        , .STAT_W(4)
`endif
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_a_v    (i_a_v),
        .i_a_d    (i_a_d),
        .i_a_last (i_a_last),
        .o_a_r    (o_a_r),
        .o_z_v    (o_z_v),
        .o_z_d    (o_z_d),
        .o_z_pad  (o_z_pad),
        .i_z_r    (i_z_r)
`ifdef CORY_PAIR_SEQ_STAT_EN
        , .o_stat_pair (o_stat_pair)
        , .o_stat_pad  (o_stat_pad)
`endif
    );

    task automatic check(input string name, input logic ok,
                         input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_have_lo = 1'b0;
        m_full    = 1'b0;
        exp_q.delete();
    endtask

    // Present one cycle of inputs; the following rising edge consumes them
    task automatic drive(input logic v, input logic [N-1:0] d,
                         input logic last, input logic zr);
        logic exp_rdy, acc, drain, load;
        @(posedge clk);
        #1;
        i_a_v = v; i_a_d = d; i_a_last = last; i_z_r = zr;
        #1;
        exp_rdy = !m_full || zr;
        check("a_ready", o_a_r === exp_rdy, 64'(o_a_r), 64'(exp_rdy));
        acc   = v && exp_rdy;
        drain = m_full && zr;
        load  = 1'b0;
        if (acc) begin
            n_words++;
            if (m_have_lo) begin
                exp_q.push_back({1'b0, d, m_lo});
                m_have_lo = 1'b0;
                load = 1'b1;
            end else if (last) begin
                exp_q.push_back({1'b1, {N{1'b0}}, d});
                load = 1'b1;
            end else begin
                m_lo = d;
                m_have_lo = 1'b1;
            end
        end
        m_full = load || (m_full && !drain);
    endtask

    // Pops one expectation per handshake; also checks stall stability
    task automatic mon_loop();
        logic           hold_prev = 1'b0;
        logic [2*N-1:0] pd = '0;
        logic           pp = 1'b0;
        logic [2*N:0]   e;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    check("stall_stable", o_z_v === 1'b1 && o_z_d === pd && o_z_pad === pp,
                          64'({o_z_v, o_z_pad, o_z_d}), 64'({1'b1, pp, pd}));
                end
                if (o_z_v === 1'b1 && i_z_r === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pair", 1'b0, 64'({o_z_pad, o_z_d}), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pair", {o_z_pad, o_z_d} === e, 64'({o_z_pad, o_z_d}), 64'(e));
                    end
                end
                hold_prev = (o_z_v === 1'b1) && (i_z_r === 1'b0);
                pd = o_z_d;
                pp = o_z_pad;
            end
        end
    endtask

    initial begin
        int cyc;
        fork
            mon_loop();
        join_none

        // Power-on reset values
        #12;
        check("rst_v",   o_z_v === 1'b0,   64'(o_z_v), 64'd0);
        check("rst_d",   o_z_d === 32'h0,  64'(o_z_d), 64'd0);
        check("rst_pad", o_z_pad === 1'b0, 64'(o_z_pad), 64'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Reset mid-pair discards the held low word
        drive(1'b1, 16'h1111, 1'b0, 1'b1);
        @(posedge clk); #1;
        i_a_v = 1'b0; reset = 1'b1;
        model_reset();
        #2;
        check("midrst_v", o_z_v === 1'b0,  64'(o_z_v), 64'd0);
        check("midrst_d", o_z_d === 32'h0, 64'(o_z_d), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        drive(1'b1, 16'h2222, 1'b0, 1'b1);
        drive(1'b1, 16'h3333, 1'b0, 1'b1);
        drive(1'b0, 16'h0,    1'b0, 1'b1);

        // Streaming four words back to back
        drive(1'b1, 16'hAAAA, 1'b0, 1'b1);
        drive(1'b1, 16'hBBBB, 1'b0, 1'b1);
        drive(1'b1, 16'hCCCC, 1'b0, 1'b1);
        drive(1'b1, 16'hDDDD, 1'b0, 1'b1);
        drive(1'b0, 16'h0,    1'b0, 1'b1);

        // Lone flush, then a pair whose second word carries last
        drive(1'b1, 16'h00F0, 1'b1, 1'b1);
        drive(1'b1, 16'h0001, 1'b0, 1'b1);
        drive(1'b1, 16'h0002, 1'b1, 1'b1);
        drive(1'b0, 16'h0,    1'b0, 1'b1);

        // Backpressure with a completing word waiting, then drain+reload
        drive(1'b1, 16'h1234, 1'b0, 1'b1);
        drive(1'b1, 16'h5678, 1'b0, 1'b0);
        repeat (5) drive(1'b1, 16'h9ABC, 1'b1, 1'b0);
        drive(1'b1, 16'h9ABC, 1'b1, 1'b1);
        drive(1'b0, 16'h0,    1'b0, 1'b0);
        check("b2b_v",   o_z_v === 1'b1,            64'(o_z_v),   64'd1);
        check("b2b_d",   o_z_d === 32'h00009ABC,    64'(o_z_d),   64'h9ABC);
        check("b2b_pad", o_z_pad === 1'b1,          64'(o_z_pad), 64'd1);
        drive(1'b0, 16'h0, 1'b0, 1'b1);

        // Random traffic
        n_words = 0;
        cyc = 0;
        while (n_words < 10000 && cyc < 40000) begin
            drive($urandom_range(0, 3) != 0, 16'($urandom),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
            cyc++;
        end
        check("rand_words", n_words >= 10000, 64'(n_words), 64'd10000);

        // Drain everything still owed
        repeat (10) drive(1'b0, 16'h0, 1'b0, 1'b1);
        check("drained", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);

`ifdef CORY_PAIR_SEQ_STAT_EN
        begin
            int e_cnt;
            @(posedge clk); #1 reset = 1'b1;
            model_reset();
            @(posedge clk); #1 reset = 1'b0;
            e_cnt = 0;
            repeat (20) begin
                drive(1'b1, 16'($urandom), 1'b1, 1'b1);
                if (e_cnt < 15) e_cnt++;
            end
            drive(1'b0, 16'h0, 1'b0, 1'b1);
            check("stat_pad",  o_stat_pad === 4'(e_cnt),  64'(o_stat_pad),  64'(e_cnt));
            check("stat_pair", o_stat_pair === 4'(e_cnt), 64'(o_stat_pair), 64'(e_cnt));
            repeat (3) drive(1'b0, 16'h0, 1'b0, 1'b1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
